// File: rtl/pipe_check_pkg.sv
// Shared encodings for the pipe data checker and its pattern generator.
package pipe_check_pkg;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_FIXED = 2'd3
  } pattern_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SAT   = 2'd2
  } chk_state_e;

  localparam logic [31:0] DEFAULT_LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/pipe_data_checker_if.sv
// FIFO read-side bus feeding the checker: data word plus its valid strobe.
interface pipe_data_checker_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;

    modport master (output data_in, output data_valid);
    modport slave  (input  data_in, input  data_valid);
endinterface

// File: rtl/pipe_pattern_gen.sv
// Test-pattern generator (increment / Galois LFSR / walking-one / fixed).
// Shared by the checker and any upstream pattern source.
module pipe_pattern_gen
    import pipe_check_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(DEFAULT_LFSR_POLY)
) (
    input  logic              okClk,
    input  pattern_mode_e     mode,
    input  logic [DATA_W-1:0] seed,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] value
);

    logic [DATA_W-1:0] seed_fix;
    logic [DATA_W-1:0] next_value;

    always_comb begin
        seed_fix = seed;
        // A zero seed would lock LFSR and walking-one patterns at zero forever
        if ((mode == MODE_LFSR || mode == MODE_WALK) && seed == '0)
            seed_fix = DATA_W'(1);

        next_value = value;
        case (mode)
            MODE_INC:   next_value = value + DATA_W'(1);
            MODE_LFSR:  next_value = (value >> 1) ^ (value[0] ? LFSR_POLY : '0);
            MODE_WALK:  next_value = {value[DATA_W-2:0], value[DATA_W-1]};
            default:    next_value = value;
        endcase
    end

    always_ff @(posedge okClk) begin
        if (load)
            value <= seed_fix;
        else if (advance)
            value <= next_value;
    end

endmodule

// File: rtl/pipe_data_checker.sv
// Checks a FIFO read stream against a generated pattern and counts mismatches.
// Define PIPE_CHECK_ERR_CAPTURE_EN to latch details of the first mismatch.
module pipe_data_checker
    import pipe_check_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(DEFAULT_LFSR_POLY)
) (
    input  logic                 okClk,
    input  logic                 reset,
    input  logic                 reset_pattern,
    input  logic [1:0]           mode,
    input  logic [DATA_W-1:0]    seed,
    pipe_data_checker_if.slave   pipe,
    output logic [31:0]          error_count,
    output logic [31:0]          word_count,
    output logic                 error_flag,
    output logic                 busy,
    output logic [31:0]          first_err_index,
    output logic [DATA_W-1:0]    first_err_expected,
    output logic [DATA_W-1:0]    first_err_actual
);

    chk_state_e        state;
    pattern_mode_e     mode_q;
    pattern_mode_e     gen_mode;
    logic [DATA_W-1:0] expected;
    logic              gen_load;
    logic              check_word;
    logic              mismatch;
    logic [31:0]       err_next;

    always_comb begin
        gen_mode   = (state == ST_IDLE) ? pattern_mode_e'(mode) : mode_q;
        check_word = pipe.data_valid && !reset_pattern;
        // IDLE keeps reloading so the expected word follows seed until the first word
        gen_load   = reset || reset_pattern || (state == ST_IDLE && !pipe.data_valid);
        mismatch   = check_word && (pipe.data_in != expected);
        err_next   = (mismatch && error_count != '1) ? error_count + 32'd1 : error_count;
    end

    pipe_pattern_gen #(
        .DATA_W    (DATA_W),
        .LFSR_POLY (LFSR_POLY)
    ) u_gen (
        .okClk   (okClk),
        .mode    (gen_mode),
        .seed    (seed),
        .load    (gen_load),
        .advance (check_word),
        .value   (expected)
    );

    always_ff @(posedge okClk) begin
        if (reset) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_INC;
            error_count <= '0;
            word_count  <= '0;
            error_flag  <= 1'b0;
            busy        <= 1'b0;
        end else if (reset_pattern) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else if (pipe.data_valid) begin
            if (state == ST_IDLE)
                mode_q <= pattern_mode_e'(mode);
            word_count  <= word_count + 32'd1;
            error_count <= err_next;
            if (mismatch)
                error_flag <= 1'b1;
            state <= (err_next == '1) ? ST_SAT : ST_CHECK;
            busy  <= 1'b1;
        end
    end

`ifdef PIPE_CHECK_ERR_CAPTURE_EN
    always_ff @(posedge okClk) begin
        if (reset) begin
            first_err_index    <= '0;
            first_err_expected <= '0;
            first_err_actual   <= '0;
        end else if (mismatch && !error_flag) begin
            first_err_index    <= word_count;
            first_err_expected <= expected;
            first_err_actual   <= pipe.data_in;
        end
    end
`else
    assign first_err_index    = '0;
    assign first_err_expected = '0;
    assign first_err_actual   = '0;
`endif

endmodule

// File: tb/tb_pipe_data_checker.sv
// Directed + randomized bench for pipe_data_checker with a word-index based reference model.
module tb_pipe_data_checker;

    localparam logic [31:0] POLY = 32'h8020_0003;

    logic        okClk = 1'b0;
    logic        reset;
    logic        reset_pattern;
    logic [1:0]  mode;
    logic [31:0] seed;
    logic [31:0] error_count, word_count;
    logic        error_flag, busy;
    logic [31:0] first_err_index, first_err_expected, first_err_actual;

    pipe_data_checker_if #(.DATA_W(32)) bus ();

    pipe_data_checker #(
        .DATA_W    (32),
        .LFSR_POLY (POLY)
    ) dut (
        .okClk              (okClk),
        .reset              (reset),
        .reset_pattern      (reset_pattern),
        .mode               (mode),
        .seed               (seed),
        .pipe               (bus.slave),
        .error_count        (error_count),
        .word_count         (word_count),
        .error_flag         (error_flag),
        .busy               (busy),
        .first_err_index    (first_err_index),
        .first_err_expected (first_err_expected),
        .first_err_actual   (first_err_actual)
    );

    initial forever #5 okClk = ~okClk;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // reference model state
    int unsigned m_ec, m_wc, m_n;
    bit          m_flag, m_active;
    logic [1:0]  m_mode;
    logic [31:0] m_seed, m_idx, m_exp, m_act;

    // n-th word of a pattern, computed directly from the pattern definition
    function automatic logic [31:0] exp_word(input logic [1:0] md, input logic [31:0] sd,
                                             input int unsigned n);
        logic [31:0] v;
        int unsigned k;
        v = (sd == 32'd0) ? 32'd1 : sd;
        case (md)
            2'd0: return sd + n;
            2'd1: begin
                for (int unsigned i = 0; i < n; i++)
                    v = {1'b0, v[31:1]} ^ (v[0] ? POLY : 32'd0);
                return v;
            end
            2'd2: begin
                k = n % 32;
                return (k == 0) ? v : ((v << k) | (v >> (32 - k)));
            end
            default: return sd;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("error_count", error_count, m_ec);
        chk("word_count",  word_count,  m_wc);
        chk("error_flag",  {31'd0, error_flag}, {31'd0, m_flag});
        chk("busy",        {31'd0, busy},       {31'd0, m_active});
`ifdef PIPE_CHECK_ERR_CAPTURE_EN
        chk("first_err_index",    first_err_index,    m_idx);
        chk("first_err_expected", first_err_expected, m_exp);
        chk("first_err_actual",   first_err_actual,   m_act);
`else
        chk("first_err_index",    first_err_index,    32'd0);
        chk("first_err_expected", first_err_expected, 32'd0);
        chk("first_err_actual",   first_err_actual,   32'd0);
`endif
    endtask

    // one clock: apply inputs at negedge, update model, check after the edge
    task automatic step(input bit rst, input bit rp, input bit dv, input logic [31:0] d);
        logic [31:0] e;
        reset = rst; reset_pattern = rp; bus.data_valid = dv; bus.data_in = d;
        if (rst) begin
            m_ec = 0; m_wc = 0; m_flag = 0; m_active = 0;
            m_idx = '0; m_exp = '0; m_act = '0;
        end else if (rp) begin
            m_active = 0;
        end else if (dv) begin
            if (!m_active) begin
                m_active = 1; m_mode = mode; m_seed = seed; m_n = 0;
            end
            e = exp_word(m_mode, m_seed, m_n);
            m_n++;
            if (d !== e) begin
                if (!m_flag) begin m_idx = m_wc; m_exp = e; m_act = d; end
                m_flag = 1;
                if (m_ec != 32'hFFFF_FFFF) m_ec++;
            end
            m_wc++;
        end
        @(posedge okClk);
        @(negedge okClk);
        check_all();
        reset = 0; reset_pattern = 0; bus.data_valid = 0;
    endtask

    task automatic send_word(input bit corrupt);
        logic [31:0] e;
        e = m_active ? exp_word(m_mode, m_seed, m_n) : exp_word(mode, seed, 0);
        if ($urandom_range(3) == 0) step(0, 0, 0, $urandom);
        step(0, 0, 1, corrupt ? (e ^ ($urandom | 32'h1)) : e);
    endtask

    initial begin
        reset = 1; reset_pattern = 0; bus.data_valid = 0; bus.data_in = '0;
        mode = 2'd0; seed = 32'd5;
        m_n = 0; m_mode = 0; m_seed = 0;
        @(negedge okClk);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h1234);

        // increment from seed 5, words 5..104
        step(0, 0, 0, 0);
        for (int i = 0; i < 100; i++) send_word(0);
        chk("inc_wc100", word_count, 32'd100);
        chk("inc_ec0",   error_count, 32'd0);

        // single corrupted word at index 3
        seed = 32'd0;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) send_word(0);
        step(0, 0, 1, 32'h0000_DEAD);
        for (int i = 0; i < 4; i++) send_word(0);
        chk("dead_ec1", error_count, 32'd1);
`ifdef PIPE_CHECK_ERR_CAPTURE_EN
        chk("dead_idx", first_err_index, 32'd3);
        chk("dead_exp", first_err_expected, 32'd3);
        chk("dead_act", first_err_actual, 32'h0000_DEAD);
`endif

        // reset_pattern coincident with a valid word, then restart from seed
        step(0, 1, 1, $urandom);
        for (int i = 0; i < 5; i++) send_word(0);

        // walking one from seed 0
        mode = 2'd2; seed = 32'd0;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 33; i++) send_word(0);
        chk("walk_ec0", error_count, 32'd0);

        // LFSR with random seed, occasional corruption, mode/seed changes ignored mid-run
        mode = 2'd1; seed = $urandom;
        step(0, 1, 0, 0);
        for (int i = 0; i < 60; i++) begin
            if (i == 30) begin mode = 2'd3; seed = $urandom; end
            send_word($urandom_range(7) == 0);
        end

        // fixed pattern
        mode = 2'd3; seed = $urandom;
        step(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) send_word($urandom_range(5) == 0);

        // walking one from a random seed
        mode = 2'd2; seed = $urandom | 32'h1;
        step(0, 1, 0, 0);
        for (int i = 0; i < 40; i++) send_word($urandom_range(9) == 0);

        // word_count wraps without disturbing the check
        force dut.word_count = 32'hFFFF_FFFF;
        #1 release dut.word_count;
        m_wc = 32'hFFFF_FFFF;
        send_word(0);
        send_word(0);
        chk("wc_wrap", word_count, 32'd1);

        // error_count saturation
        force dut.error_count = 32'hFFFF_FFFE;
        #1 release dut.error_count;
        m_ec = 32'hFFFF_FFFE;
        send_word(1);
        send_word(1);
        send_word(1);
        send_word(0);
        chk("sat_ec", error_count, 32'hFFFF_FFFF);
        chk("sat_busy", {31'd0, busy}, 32'd1);
        step(0, 1, 0, 0);
        send_word(1);

        // reset mid-check with a valid word present
        mode = 2'd0; seed = $urandom;
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) send_word(0);
        step(1, 0, 1, $urandom);
        chk("rst_wc", word_count, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_data_checker.md
PIPE_DATA_CHECKER -- requirements
Module: pipe_data_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter LFSR_POLY, default 32'h8020_0003, Galois LFSR tap mask.
REQ-003 SHALL have port okClk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset; clock okClk.
REQ-005 SHALL have port reset_pattern  input  1  one-cycle pulse; reloads generator, returns to IDLE.
REQ-006 SHALL have port mode  input  2  pattern: 0 increment, 1 LFSR, 2 walking-one, 3 fixed.
REQ-007 SHALL have port seed  input  DATA_W  first expected word.
REQ-008 SHALL have port data_in  input  DATA_W  FIFO read data.
REQ-009 SHALL have port data_valid  input  1  data_in valid this cycle (FIFO rd_en delayed one cycle).
REQ-010 SHALL have port error_count  output  32  mismatched words.
REQ-011 SHALL have port word_count  output  32  checked words.
REQ-012 SHALL have port error_flag  output  1  sticky, set on first mismatch.
REQ-013 SHALL have port busy  output  1  high in CHECK or SAT.
REQ-014 SHALL have ports first_err_index  output  32, first_err_expected  output  DATA_W, first_err_actual  output  DATA_W.

Function
REQ-015 SHALL implement FSM IDLE, CHECK, SAT.
REQ-016 IDLE: expected register holds seed (tracks seed continuously); mode latched on first data_valid, which is checked and moves FSM to CHECK.
REQ-017 CHECK: each data_valid cycle compares data_in with expected, increments word_count, increments error_count on mismatch, advances expected.
REQ-018 Advance rules: increment = +1 mod 2^DATA_W; LFSR = shift right, XOR LFSR_POLY if shifted-out bit is 1; walking-one = rotate left 1; fixed = unchanged.
REQ-019 LFSR or walking-one with seed 0 SHALL load 1 instead (avoid lock-up).
REQ-020 All outputs registered; counts and error_flag reflect a word one cycle after its data_valid.
REQ-021 error_count reaching 32'hFFFF_FFFF SHALL move FSM to SAT: error_count frozen, word_count and expected keep advancing.
REQ-022 word_count SHALL wrap 32'hFFFF_FFFF -> 0 without affecting FSM.
REQ-023 mode/seed changes outside IDLE SHALL be ignored.
REQ-024 reset_pattern: FSM -> IDLE, expected <- seed; counters, error_flag, capture unchanged.
REQ-025 reset_pattern coincident with data_valid: reset_pattern wins; word not checked or counted.
REQ-026 data_valid low: no state, counter or expected change.

Reset
REQ-027 reset SHALL dominate reset_pattern and data_valid.
REQ-028 On reset: FSM IDLE, error_count 0, word_count 0, error_flag 0, busy 0, expected <- seed, capture outputs 0.

Configuration
REQ-029 Macro PIPE_CHECK_ERR_CAPTURE_EN defined: on first mismatch after reset, latch word_count value (index), expected, data_in into first_err_*; hold until reset.
REQ-030 Macro undefined: first_err_* ports present, tied to 0; no capture registers.

Structure
REQ-031 Package pipe_check_pkg SHALL hold mode encodings, FSM state encoding, default LFSR_POLY.
REQ-032 Sub-module pipe_pattern_gen (mode, seed, load, advance -> value) SHALL hold the generator, reusable by an upstream pattern source.

Verification
REQ-033 mode 0, seed 5, words 5..104 -> word_count 100, error_count 0, error_flag 0.
REQ-034 mode 0, seed 0, word 3 sent as 0xDEAD -> error_count 1, first_err_index 3, expected 3, actual 0xDEAD (with macro).
REQ-035 mode 2, seed 0, 33 words 1,2,4,...,0x8000_0000,1 -> error_count 0.
REQ-036 reset_pattern coincident with data_valid in CHECK -> word_count unchanged; next word compared against seed.
REQ-037 error_count forced to 0xFFFF_FFFE, two bad words -> saturates 0xFFFF_FFFF, SAT, word_count +2.
REQ-038 reset mid-CHECK with data_valid high -> all outputs 0 next cycle, FSM IDLE.
